// File: rtl/aes_job_controller.sv
// rtl/aes_job_controller.sv - sequences one AES job: word reads, core run, word writes, status
module aes_job_controller #(
    parameter int unsigned ADDR_W    = 32,
    parameter logic [31:0] MAX_BYTES = 32'h0010_0000
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              signal,
    input  logic [1:0]        flag,
    input  logic [31:0]       data_read_loc,
    input  logic [31:0]       data_write_loc,
    input  logic [31:0]       size_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              aes_start,
    output logic              aes_mode,
    output logic [127:0]      aes_in,
    input  logic              aes_done,
    input  logic [127:0]      aes_out,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHECK, ST_RD_REQ, ST_RD_WAIT, ST_AES_RUN, ST_WR_REQ, ST_DONE, ST_ERR
    } state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]         remaining_q;
    logic [1:0]          idx_q;
    logic [127:0]        result_q;
    logic                mem_req_q, mem_we_q, aes_start_q, aes_mode_q;
    logic                busy_q, done_q, error_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic [127:0]        aes_in_q;

    logic [ADDR_W-1:0]   rd_ptr_d, wr_ptr_d;
    logic [31:0]         remaining_d;
    logic [1:0]          idx_d;
    logic [31:0]         wr_word_d;
    logic                cfg_bad;

    always_comb begin
        rd_ptr_d    = rd_ptr_q + ADDR_W'(4);
        wr_ptr_d    = wr_ptr_q + ADDR_W'(4);
        idx_d       = idx_q + 2'd1;
        remaining_d = remaining_q - 32'd16;
        cfg_bad     = !(mode_q == 2'b01 || mode_q == 2'b10) ||
                      (remaining_q[3:0] != 4'd0) ||
                      (remaining_q > MAX_BYTES) ||
                      (rd_ptr_q[1:0] != 2'b00) ||
                      (wr_ptr_q[1:0] != 2'b00);
        // Word following the one currently on the write bus, MSW first.
        case (idx_d)
            2'd0:    wr_word_d = result_q[127:96];
            2'd1:    wr_word_d = result_q[95:64];
            2'd2:    wr_word_d = result_q[63:32];
            default: wr_word_d = result_q[31:0];
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 2'b00;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            remaining_q <= 32'd0;
            idx_q       <= 2'd0;
            result_q    <= 128'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            aes_start_q <= 1'b0;
            aes_mode_q  <= 1'b0;
            aes_in_q    <= 128'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (signal) begin
                    mode_q      <= flag;
                    aes_mode_q  <= (flag == 2'b10);
                    rd_ptr_q    <= data_read_loc[ADDR_W-1:0];
                    wr_ptr_q    <= data_write_loc[ADDR_W-1:0];
                    remaining_q <= size_data;
                    error_q     <= 1'b0;
                    busy_q      <= 1'b1;
                    state_q     <= ST_CHECK;
                end
                ST_CHECK: begin
                    idx_q <= 2'd0;
                    if (cfg_bad) begin
                        error_q <= 1'b1;
                        state_q <= ST_ERR;
                    end else if (remaining_q == 32'd0) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= rd_ptr_q;
                        state_q    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: if (mem_gnt) begin
                    mem_req_q <= 1'b0;
                    state_q   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: if (mem_rvalid) begin
                    case (idx_q)
                        2'd0:    aes_in_q[127:96] <= mem_rdata;
                        2'd1:    aes_in_q[95:64]  <= mem_rdata;
                        2'd2:    aes_in_q[63:32]  <= mem_rdata;
                        default: aes_in_q[31:0]   <= mem_rdata;
                    endcase
                    rd_ptr_q <= rd_ptr_d;
                    if (idx_q == 2'd3) begin
                        aes_start_q <= 1'b1;
                        state_q     <= ST_AES_RUN;
                    end else begin
                        idx_q      <= idx_d;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= rd_ptr_d;
                        state_q    <= ST_RD_REQ;
                    end
                end
                ST_AES_RUN: begin
                    aes_start_q <= 1'b0;
                    if (aes_done) begin
                        result_q    <= aes_out;
                        idx_q       <= 2'd0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_ptr_q;
                        mem_wdata_q <= aes_out[127:96];
                        state_q     <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: if (mem_gnt) begin
                    wr_ptr_q <= wr_ptr_d;
                    if (idx_q != 2'd3) begin
                        idx_q       <= idx_d;
                        mem_addr_q  <= wr_ptr_d;
                        mem_wdata_q <= wr_word_d;
                    end else begin
                        mem_we_q    <= 1'b0;
                        idx_q       <= 2'd0;
                        remaining_q <= remaining_d;
                        if (remaining_d == 32'd0) begin
                            mem_req_q <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            // Request stays up: the next block's first read follows directly.
                            mem_addr_q <= rd_ptr_q;
                            state_q    <= ST_RD_REQ;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign aes_start = aes_start_q;
    assign aes_mode  = aes_mode_q;
    assign aes_in    = aes_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_aes_job_controller.sv
// tb/tb_aes_job_controller.sv - scoreboard bench for aes_job_controller with memory and AES models
`timescale 1ns/1ps
module tb_aes_job_controller;

    localparam logic [31:0] MAX_BYTES = 32'h0010_0000;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic         hclk = 1'b0, hreset = 1'b1, signal = 1'b0;
    logic [1:0]   flag = 2'b00;
    logic [31:0]  data_read_loc = 32'd0, data_write_loc = 32'd0, size_data = 32'd0;
    logic         mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata = 32'd0;
    logic         aes_start, aes_mode, aes_done = 1'b0;
    logic [127:0] aes_in, aes_out = 128'd0;
    logic         busy, done, error;

    int vectors = 0;
    int miscompares = 0;
    int gnt_wait = 0;
    int aes_lat = 5;

    logic [31:0]  exp_rd[$];
    logic [63:0]  exp_wr[$];
    logic [128:0] exp_aes[$];
    int           exp_evt[$];

    aes_job_controller dut (
        .hclk(hclk), .hreset(hreset), .signal(signal), .flag(flag),
        .data_read_loc(data_read_loc), .data_write_loc(data_write_loc), .size_data(size_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .aes_start(aes_start), .aes_mode(aes_mode), .aes_in(aes_in),
        .aes_done(aes_done), .aes_out(aes_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 hclk = ~hclk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] aes_fn(input logic [127:0] x, input logic dec);
        if (dec) return ~x ^ {4{32'hC3C3_0F0F}};
        return {x[95:0], x[127:96]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred, none expected", nm);
    endtask

    // Reference: expected reads, core inputs, writes and the closing event of one job.
    task automatic push_job(input logic [1:0] f, input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] sz);
        logic [127:0] blk = 128'd0;
        logic [127:0] res;
        logic [31:0]  a;
        int           nblk;
        if (!(f == 2'b01 || f == 2'b10) || sz[3:0] != 4'd0 || sz > MAX_BYTES ||
            src[1:0] != 2'b00 || dst[1:0] != 2'b00) begin
            exp_evt.push_back(EV_ERR);
            return;
        end
        nblk = int'(sz >> 4);
        for (int b = 0; b < nblk; b++) begin
            for (int k = 0; k < 4; k++) begin
                a = src + 32'(16 * b + 4 * k);
                exp_rd.push_back(a);
                blk = {blk[95:0], mem_word(a)};
            end
            exp_aes.push_back({(f == 2'b10), blk});
            res = aes_fn(blk, f == 2'b10);
            for (int k = 0; k < 4; k++)
                exp_wr.push_back({dst + 32'(16 * b + 4 * k), res[127 - 32 * k -: 32]});
        end
        exp_evt.push_back(EV_DONE);
    endtask

    initial begin : mem_resp
        int waited = 0;
        bit pend = 1'b0;
        logic [31:0] paddr = 32'd0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0; pend = 1'b0; waited = 0;
            end else begin
                mem_rvalid = pend;
                mem_rdata  = pend ? mem_word(paddr) : 32'd0;
                pend       = 1'b0;
                mem_gnt    = 1'b0;
                if (mem_req) begin
                    if (waited >= gnt_wait) begin
                        mem_gnt = 1'b1;
                        waited  = 0;
                        if (!mem_we) begin pend = 1'b1; paddr = mem_addr; end
                    end else begin
                        waited++;
                    end
                end
            end
        end
    end

    initial begin : aes_model
        int cnt = 0;
        logic [127:0] hold = 128'd0;
        forever begin
            @(negedge hclk);
            aes_done = 1'b0;
            if (hreset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin aes_done = 1'b1; aes_out = hold; end
                end
                if (aes_start) begin
                    hold = aes_fn(aes_in, aes_mode);
                    if (aes_lat == 0) begin aes_done = 1'b1; aes_out = hold; end
                    else cnt = aes_lat;
                end
            end
        end
    end

    initial begin : monitor
        logic pw = 1'b0, pwe = 1'b0, pdone = 1'b0, perr = 1'b0;
        logic [31:0] pa = 32'd0, pd = 32'd0;
        logic [63:0] w;
        logic [128:0] ab;
        int ev;
        forever begin
            @(negedge hclk);
            #2;
            if (hreset) begin
                pw = 1'b0; pdone = 1'b0; perr = 1'b0;
            end else begin
                if (pw)
                    check("req_hold", {mem_req, mem_we, mem_addr, pwe ? mem_wdata : 32'd0},
                          {1'b1, pwe, pa, pwe ? pd : 32'd0});
                if (mem_req && mem_gnt) begin
                    if (mem_we) begin
                        if (exp_wr.size() == 0) fail_now("unexpected_write");
                        else begin
                            w = exp_wr.pop_front();
                            check("wr_addr", mem_addr, w[63:32]);
                            check("wr_data", mem_wdata, w[31:0]);
                        end
                    end else begin
                        if (exp_rd.size() == 0) fail_now("unexpected_read");
                        else check("rd_addr", mem_addr, exp_rd.pop_front());
                    end
                end
                pw = mem_req && !mem_gnt; pwe = mem_we; pa = mem_addr; pd = mem_wdata;
                if (aes_start) begin
                    if (exp_aes.size() == 0) fail_now("unexpected_aes_start");
                    else begin
                        ab = exp_aes.pop_front();
                        check("aes_mode_in", {aes_mode, aes_in}, ab);
                    end
                end
                if (done) begin
                    check("busy_at_done", busy, 1'b1);
                    if (exp_evt.size() == 0) fail_now("unexpected_done");
                    else begin ev = exp_evt.pop_front(); check("done_event", ev, EV_DONE); end
                end
                if (pdone) check("busy_after_done", busy, 1'b0);
                if (error && !perr) begin
                    if (exp_evt.size() == 0) fail_now("unexpected_error");
                    else begin ev = exp_evt.pop_front(); check("error_event", ev, EV_ERR); end
                end
                pdone = done; perr = error;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: time limit reached, busy=%0b", busy);
        $fatal(1, "watchdog");
    end

    task automatic start_job(input logic [1:0] f, input logic [31:0] s, input logic [31:0] d,
                             input logic [31:0] z);
        push_job(f, s, d, z);
        @(negedge hclk);
        flag = f; data_read_loc = s; data_write_loc = d; size_data = z; signal = 1'b1;
        @(negedge hclk);
        signal = 1'b0;
        flag = 2'($urandom); data_read_loc = $urandom; data_write_loc = $urandom; size_data = $urandom;
        #2;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 4000) begin @(negedge hclk); #2; n++; end
        check({nm, "_idle"}, busy, 1'b0);
        check({nm, "_drain"}, 32'(exp_rd.size() + exp_wr.size() + exp_aes.size() + exp_evt.size()), 32'd0);
    endtask

    initial begin : stimulus
        logic [1:0]  f;
        logic [31:0] s, d, z;
        int r, n;
        hreset = 1'b1;
        repeat (3) @(negedge hclk);
        check("reset_outputs", {busy, done, error, mem_req, aes_start}, 5'd0);
        hreset = 1'b0;
        repeat (10) @(negedge hclk);
        #2;
        check("idle_outputs", {busy, done, error, mem_req, aes_start, mem_we}, 6'd0);

        gnt_wait = 0; aes_lat = 5;
        start_job(2'b01, 32'h100, 32'h200, 32'd32);
        wait_idle("encrypt");

        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       start_job(2'b01, 32'h100, 32'h200, 32'd20);
                1:       start_job(2'b11, 32'h100, 32'h200, 32'd16);
                2:       start_job(2'b10, 32'h102, 32'h200, 32'd16);
                default: start_job(2'b01, 32'h100, 32'h200, MAX_BYTES + 32'd16);
            endcase
            wait_idle("illegal");
            check("error_sticky", error, 1'b1);
        end
        start_job(2'b10, 32'h400, 32'h500, 32'd16);
        check("error_cleared", error, 1'b0);
        wait_idle("after_error");

        gnt_wait = 3;
        start_job(2'b10, 32'h1000, 32'h2000, 32'd48);
        wait_idle("backpressure");
        gnt_wait = 0;

        start_job(2'b01, 32'h3000, 32'h3100, 32'd16);
        repeat (3) @(negedge hclk);
        flag = 2'b10; data_read_loc = 32'h7000; data_write_loc = 32'h7100; size_data = 32'd16;
        signal = 1'b1;
        @(negedge hclk);
        signal = 1'b0;
        #2;
        wait_idle("busy_start");

        start_job(2'b01, 32'h40, 32'h80, 32'd0);
        check("size0_cycle1", {busy, done}, 2'b10);
        @(negedge hclk); #2;
        check("size0_cycle2", {busy, done}, 2'b11);
        wait_idle("size0");

        aes_lat = 20;
        start_job(2'b01, 32'h500, 32'h600, 32'd16);
        n = 0;
        while (!aes_start && n < 200) begin @(negedge hclk); #2; n++; end
        check("reached_aes_run", aes_start, 1'b1);
        #1;
        hreset = 1'b1;
        #1;
        check("rst_ctl", {busy, done, error, mem_req, mem_we, aes_start, aes_mode}, 7'd0);
        check("rst_bus", {mem_addr, mem_wdata}, 64'd0);
        check("rst_aes_in", aes_in, 128'd0);
        exp_rd.delete(); exp_wr.delete(); exp_aes.delete(); exp_evt.delete();
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        aes_lat = 5;
        start_job(2'b10, 32'hFFFF_FFE0, 32'h10, 32'd32);
        wait_idle("after_reset_wrap");

        for (int j = 0; j < 10; j++) begin
            gnt_wait = $urandom_range(0, 2);
            aes_lat  = $urandom_range(0, 6);
            r = $urandom_range(0, 9);
            f = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : ((r % 2) != 0) ? 2'b01 : 2'b10;
            z = 32'(16 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) z = z + 32'd8;
            s = $urandom & 32'hFFFF_FFFC;
            d = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) s[1] = 1'b1;
            start_job(f, s, d, z);
            wait_idle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_job_controller.md
Name: aes_job_controller

Overview:
- Sequences one AES job from the configuration registers held by the AHB slave.
- On the start pulse it fetches 128-bit blocks word by word from source memory through a simple single-outstanding memory master port, drives the AES core, and writes each result block to destination memory.
- Reports busy, done and error status back to the register block. Sits between the AHB config slave, the AES core and the memory fabric.

Parameters:
- ADDR_W, 32, memory address width.
- MAX_BYTES, 32'h0010_0000, largest legal job length in bytes; anything larger flags an error.

Ports:
- hclk  in  1  clock.
- hreset  in  1  asynchronous, active-high reset.
- signal  in  1  start pulse (one cycle) from the config slave.
- flag  in  2  mode: 2'b01 encrypt, 2'b10 decrypt, others illegal.
- data_read_loc  in  32  source byte address.
- data_write_loc  in  32  destination byte address.
- size_data  in  32  job length in bytes.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word address (byte address, 4-aligned).
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- aes_start  out  1  one-cycle start to the AES core.
- aes_mode  out  1  1 = decrypt.
- aes_in  out  128  block to the core.
- aes_done  in  1  one-cycle completion from the core.
- aes_out  in  128  result block.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at successful job end.
- error  out  1  sticky; cleared by the next accepted start.

Behaviour:
- Reset: all outputs 0; internal address and byte counters 0; state IDLE.
- Reset mid-job is immediate. Any pending memory request is abandoned with no cleanup; the fabric must tolerate this.
- States: IDLE, CHECK, RD_REQ, RD_WAIT, AES_RUN, WR_REQ, DONE, ERR.
- IDLE:
  - busy=0.
  - signal=1 latches flag, both addresses and size_data, clears error, and goes to CHECK.
  - signal while not IDLE is ignored (no latch, no error).
- CHECK (1 cycle), busy=1:
  - Go to ERR if any of: flag not 01/10; size_data[3:0]!=0; size_data>MAX_BYTES; data_read_loc[1:0]!=0; data_write_loc[1:0]!=0.
  - size_data==0 goes to DONE.
  - Otherwise go to RD_REQ with word index 0.
- RD_REQ:
  - mem_req=1, mem_we=0, mem_addr=rd_ptr. Hold all of these stable until mem_gnt.
  - On gnt go to RD_WAIT.
- RD_WAIT:
  - mem_req=0. On mem_rvalid, store the word: index 0 to aes_in[127:96], 1 to [95:64], 2 to [63:32], 3 to [31:0].
  - Then rd_ptr+=4.
  - If index<3: index++ and go to RD_REQ.
  - If index==3: go to AES_RUN and assert aes_start for exactly the first cycle.
  - mem_rvalid in any other state is ignored.
- AES_RUN:
  - aes_in and aes_mode are held stable.
  - On aes_done, capture aes_out into the result register, reset index to 0, and go to WR_REQ.
  - aes_done on the same cycle as aes_start is legal and accepted.
- WR_REQ:
  - mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=result word[index], same ordering as reads. Hold until mem_gnt.
  - On gnt: wr_ptr+=4.
  - If index<3: index++ and stay in WR_REQ (back-to-back writes allowed).
  - Else: remaining-=16. Go to DONE if remaining==0, otherwise to RD_REQ.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error=1 (sticky), then IDLE; no memory traffic issued.
- Address arithmetic is modulo 2^ADDR_W; wrap past 0xFFFF_FFFC is allowed and not flagged.
- Latency:
  - Per block = 4×(gnt wait + read latency + 1) + AES latency + 4 write grants + state overhead.
  - With zero-wait memory (gnt same cycle, rvalid next cycle): 8 read cycles + 1 + AES + 4.
- Config inputs may change after start without affecting the running job.

Test Plan:
- Reset, then idle 10 cycles -> busy=done=error=mem_req=aes_start=0.
- Encrypt job: flag=01, src=0x100, dst=0x200, size=32, zero-wait memory, AES model with 5-cycle latency. Expected:
  - Reads at 0x100..0x11C in order; two aes_start pulses with aes_mode=0.
  - Writes at 0x200..0x21C carry aes_out words MSW first.
  - A single done pulse; busy falls the cycle after done.
- Illegal config: size=20; or flag=11; or src=0x102 -> error=1, no mem_req ever, no done. A following legal start clears error.
- Backpressure: mem_gnt low for 3 cycles on each request -> mem_addr/mem_wdata/mem_we stable while mem_req is high; data correct.
- Start pulse during busy, and size=0 -> the busy start is ignored; the size-0 job gives done two cycles after signal with no memory traffic.
- hreset asserted in AES_RUN -> all outputs 0 immediately (asynchronous); a new job after release completes correctly.
